// File: rtl/fifo_buffer_if.sv
// Handshake/bus bundle for fifo_buffer.
// master: the producer/consumer side that issues push/pop.
// slave : the FIFO itself.
interface fifo_buffer_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [3:0]            count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_buffer.sv
// fifo_buffer: 8-entry synchronous FIFO with registered read port.
// Pointers are 3 bits plus a wrap bit; full/empty come from pointer and
// wrap comparison of the next state, so all flags are registered.
// Optional threshold flags: define FIFO_THRESH_EN to drive almost_full /
// almost_empty; without it both flags are tied to 0 and no comparators exist.
module fifo_buffer #(
  parameter int DATA_WIDTH = 10,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic            clk,
  input  logic            reset,
  fifo_buffer_if.slave    bus
);

  logic [DATA_WIDTH-1:0] mem_r [0:7];

  logic [2:0]            wr_ptr_r;
  logic                  wr_wrap_r;
  logic [2:0]            rd_ptr_r;
  logic                  rd_wrap_r;
  logic [3:0]            count_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  af_r;
  logic                  ae_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_r;
  logic                  ovf_r;
  logic                  unf_r;

  logic                  push_ok_s;
  logic                  pop_ok_s;
  logic                  ovf_s;
  logic                  unf_s;
  logic [2:0]            wr_ptr_n_s;
  logic                  wr_wrap_n_s;
  logic [2:0]            rd_ptr_n_s;
  logic                  rd_wrap_n_s;
  logic [3:0]            count_n_s;
  logic                  full_n_s;
  logic                  empty_n_s;
  logic                  af_n_s;
  logic                  ae_n_s;

`ifdef FIFO_THRESH_EN
  localparam logic [3:0] AF_LVL = 4'(AF_THRESH);
  localparam logic [3:0] AE_LVL = 4'(AE_THRESH);
  localparam logic       AE_RST = 1'b1;
`else
  localparam logic       AE_RST = 1'b0;
`endif

  // Acceptance decisions and next-state pointers/flags for this edge.
  always_comb begin
    push_ok_s   = 1'b0;
    pop_ok_s    = 1'b0;
    ovf_s       = 1'b0;
    unf_s       = 1'b0;
    wr_ptr_n_s  = wr_ptr_r;
    wr_wrap_n_s = wr_wrap_r;
    rd_ptr_n_s  = rd_ptr_r;
    rd_wrap_n_s = rd_wrap_r;
    af_n_s      = 1'b0;
    ae_n_s      = 1'b0;

    // A pop drains one slot, so a push on a full FIFO is fine when paired with a pop.
    pop_ok_s  = bus.pop & ~empty_r;
    push_ok_s = bus.push & (~full_r | bus.pop);
    ovf_s     = bus.push & full_r & ~bus.pop;
    unf_s     = bus.pop & empty_r;

    if (push_ok_s) begin
      {wr_wrap_n_s, wr_ptr_n_s} = {wr_wrap_r, wr_ptr_r} + 4'd1;
    end else begin
      {wr_wrap_n_s, wr_ptr_n_s} = {wr_wrap_r, wr_ptr_r};
    end

    if (pop_ok_s) begin
      {rd_wrap_n_s, rd_ptr_n_s} = {rd_wrap_r, rd_ptr_r} + 4'd1;
    end else begin
      {rd_wrap_n_s, rd_ptr_n_s} = {rd_wrap_r, rd_ptr_r};
    end

    count_n_s = count_r + {3'd0, push_ok_s} - {3'd0, pop_ok_s};
    full_n_s  = (wr_ptr_n_s == rd_ptr_n_s) && (wr_wrap_n_s != rd_wrap_n_s);
    empty_n_s = (wr_ptr_n_s == rd_ptr_n_s) && (wr_wrap_n_s == rd_wrap_n_s);

`ifdef FIFO_THRESH_EN
    af_n_s = (count_n_s >= AF_LVL);
    ae_n_s = (count_n_s <= AE_LVL);
`else
    af_n_s = 1'b0;
    ae_n_s = 1'b0;
`endif
  end

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= bus.data_in;
    end
  end

  // Control state, read port and status flags with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r   <= 3'd0;
      wr_wrap_r  <= 1'b0;
      rd_ptr_r   <= 3'd0;
      rd_wrap_r  <= 1'b0;
      count_r    <= 4'd0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      af_r       <= 1'b0;
      ae_r       <= AE_RST;
      data_out_r <= '0;
      valid_r    <= 1'b0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_n_s;
      wr_wrap_r  <= wr_wrap_n_s;
      rd_ptr_r   <= rd_ptr_n_s;
      rd_wrap_r  <= rd_wrap_n_s;
      count_r    <= count_n_s;
      full_r     <= full_n_s;
      empty_r    <= empty_n_s;
      af_r       <= af_n_s;
      ae_r       <= ae_n_s;
      valid_r    <= pop_ok_s;
      ovf_r      <= ovf_s;
      unf_r      <= unf_s;
      // Old head is read even when the same slot is written this edge.
      if (pop_ok_s) begin
        data_out_r <= mem_r[rd_ptr_r];
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  assign bus.data_out     = data_out_r;
  assign bus.valid_out    = valid_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.count        = count_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;

endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer: directed corner cases followed by
// randomized traffic, compared against a queue-based reference model.
module tb_fifo_buffer;

  localparam int DW = 10;

  logic clk;
  logic reset;

  fifo_buffer_if #(.DATA_WIDTH(DW)) bus ();

  fifo_buffer #(.DATA_WIDTH(DW), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then compare every output.
  task automatic step(input logic p, input logic r, input logic [DW-1:0] d, input logic rst);
    int sz;
    logic exp_af;
    logic exp_ae;
    @(negedge clk);
    bus.push    = p;
    bus.pop     = r;
    bus.data_in = d;
    reset       = rst;

    if (!rst) begin
      q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      sz      = q.size();
      m_ovf   = p && (sz == 8) && !r;
      m_unf   = r && (sz == 0);
      m_valid = r && (sz > 0);
      if (m_valid) m_data = q.pop_front();
      if (p && (sz < 8 || m_valid)) q.push_back(d);
    end

    @(posedge clk);
    #1;
    sz = q.size();
`ifdef FIFO_THRESH_EN
    exp_af = (sz >= 6);
    exp_ae = (sz <= 2);
`else
    exp_af = 1'b0;
    exp_ae = 1'b0;
`endif
    chk("count",        32'(bus.count),        32'(sz));
    chk("full",         32'(bus.full),         32'(sz == 8));
    chk("empty",        32'(bus.empty),        32'(sz == 0));
    chk("valid_out",    32'(bus.valid_out),    32'(m_valid));
    chk("data_out",     32'(bus.data_out),     32'(m_data));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.underflow),    32'(m_unf));
    chk("almost_full",  32'(bus.almost_full),  32'(exp_af));
    chk("almost_empty", 32'(bus.almost_empty), 32'(exp_ae));
  endtask

  initial begin
    int pp;
    int rp;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    reset       = 1'b0;
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;

    // Reset with push/pop asserted: reset must win.
    step(1'b1, 1'b1, 10'h155, 1'b0);
    step(1'b0, 1'b0, 10'h000, 1'b0);

    // Fill with 1..8, then overflow attempt.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i), 1'b1);
    step(1'b1, 1'b0, 10'h3FF, 1'b1);
    step(1'b0, 1'b0, 10'h000, 1'b1);

    // Simultaneous push+pop while full: old head returned, count stays 8.
    step(1'b1, 1'b1, 10'h009, 1'b1);

    // Drain, then extra pop for underflow.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 10'h000, 1'b1);
    step(1'b0, 1'b1, 10'h000, 1'b1);
    step(1'b0, 1'b0, 10'h000, 1'b1);

    // Simultaneous push+pop while empty: push in, pop rejected.
    step(1'b1, 1'b1, 10'h0AA, 1'b1);
    step(1'b0, 1'b1, 10'h000, 1'b1);

    // 12 pushes interleaved with pops across the wrap point.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, DW'(10'h100 + i), 1'b1);
      if (i % 3 == 2) step(1'b0, 1'b1, 10'h000, 1'b1);
    end
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 10'h000, 1'b1);

    // Reset mid-operation with five entries held.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(10'h050 + i), 1'b1);
    step(1'b1, 1'b1, 10'h077, 1'b0);
    step(1'b0, 1'b1, 10'h000, 1'b1);

    // Randomized traffic in phases biased toward filling, draining and mixing.
    for (int ph = 0; ph < 6; ph++) begin
      case (ph % 3)
        0:       begin pp = 80; rp = 30; end
        1:       begin pp = 25; rp = 80; end
        default: begin pp = 55; rp = 55; end
      endcase
      for (int c = 0; c < 80; c++) begin
        step(($urandom_range(0, 99) < pp) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
             DW'($urandom),
             ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 10, width of each stored word.
REQ-002 Parameter AF_THRESH, default 6, occupancy at or above which almost_full asserts.
REQ-003 Parameter AE_THRESH, default 2, occupancy at or below which almost_empty asserts.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 push  input  1  write request; data_in stored when accepted.
REQ-007 data_in  input  DATA_WIDTH  word to write.
REQ-008 pop  input  1  read request.
REQ-009 data_out  output  DATA_WIDTH  registered read word.
REQ-010 valid_out  output  1  one-cycle pulse qualifying data_out.
REQ-011 full  output  1  occupancy == 8.
REQ-012 empty  output  1  occupancy == 0.
REQ-013 almost_full  output  1  threshold flag, see REQ-030.
REQ-014 almost_empty  output  1  threshold flag, see REQ-030.
REQ-015 count  output  4  current occupancy, 0..8.
REQ-016 overflow  output  1  one-cycle pulse on rejected push.
REQ-017 underflow  output  1  one-cycle pulse on rejected pop.

Function
REQ-018 Storage SHALL be 8 entries of DATA_WIDTH bits, addressed by 3-bit write and read pointers.
REQ-019 Each pointer SHALL carry a wrap bit toggled when the pointer advances from 7 to 0.
REQ-020 full SHALL be asserted when pointers are equal and wrap bits differ; empty when pointers and wrap bits are equal.
REQ-021 full, empty and count SHALL be registered and reflect state after the current edge's updates.
REQ-022 Push accepted when push=1 and full=0: mem[wr_ptr] <= data_in, wr_ptr advances.
REQ-023 Pop accepted when pop=1 and empty=0: data_out <= mem[rd_ptr], rd_ptr advances, valid_out=1 next cycle; read latency 1 cycle.
REQ-024 When no pop is accepted, valid_out SHALL be 0 and data_out SHALL hold its previous value.
REQ-025 Push while full and pop=0: push ignored, overflow pulses 1 cycle, state unchanged.
REQ-026 Pop while empty: pop ignored, underflow pulses 1 cycle, no valid_out.
REQ-027 Push and pop together while full: both accepted, data_out returns old entry, count stays 8, no overflow.
REQ-028 Push and pop together while empty: push accepted, pop rejected with underflow, count becomes 1.
REQ-029 Push and pop together otherwise: both accepted, count unchanged.
REQ-030 almost_full = (count >= AF_THRESH); almost_empty = (count <= AE_THRESH); both registered with count.
REQ-031 Ordering SHALL be strict first-in first-out across pointer wrap-around.

Reset
REQ-032 When reset=0 at a rising edge: pointers, wrap bits, count, data_out, valid_out, full, overflow, underflow = 0; empty = 1; almost_empty = 1 (if enabled); almost_full = 0.
REQ-033 Reset SHALL override push/pop in the same cycle, including mid-operation with FIFO partially full.
REQ-034 Storage array contents SHALL NOT be reset.

Configuration
REQ-035 Macro FIFO_THRESH_EN defined: almost_full/almost_empty driven per REQ-030.
REQ-036 FIFO_THRESH_EN undefined: almost_full and almost_empty tied to 0, threshold comparators absent; all other behaviour identical.

Verification
REQ-037 Reset, 8 pushes 0x001..0x008 -> full=1 after 8th edge, count=8, almost_full=1 from count 6.
REQ-038 9th push while full -> overflow=1 for one cycle, count stays 8, contents unchanged.
REQ-039 8 pops after REQ-037 -> data_out 0x001..0x008 in order, each 1 cycle after pop, empty=1 at end; extra pop -> underflow pulse, valid_out=0.
REQ-040 12 pushes interleaved with pops across wrap-around -> output order matches input order, wrap bits toggle, full/empty correct.
REQ-041 Simultaneous push+pop when full -> count=8, no overflow, old head returned; when empty -> count=1, underflow=1.
REQ-042 reset=0 asserted with count=5 -> next cycle count=0, empty=1, valid_out=0; rebuild with FIFO_THRESH_EN undefined -> almost flags always 0.
